retire_unit: RTL and testbench

In-order retirement stage for the out-of-order core; it is the consumer of the reorder buffer's entry array. Each cycle it inspects the entry at its head pointer. Once that entry has executed and is non-speculative, it does three things:
- writes the result to the architectural register file, or performs the store through a memory handshake;
- tells the buffer to free the slot;
- advances the head.

It also keeps the retired-instruction counter.

---
 rtl/retire_unit_pkg.sv | 54 +++++
 rtl/retire_unit_if.sv | 37 +++
 rtl/retire_unit.sv | 141 ++++++++++++++
 tb/tb_retire_unit.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/retire_unit_pkg.sv
// Shared definitions for the reorder buffer and its producers and consumers.
// This file holds the buffer geometry, the entry state encoding, the entry record
// and the meaning of the rwmm memory-operation field.
package retire_unit_pkg;

   localparam int BUF_SIZE_LOG = 4;
   localparam int BUF_SIZE     = 2 ** BUF_SIZE_LOG;
   localparam int TAG_W        = BUF_SIZE_LOG + 1;
   localparam int SPEC_TAG_W   = 6;

   // rwmm[2] marks a memory write; rwmm[1:0] is the access size
   localparam int         RWMM_WRITE_BIT = 2;
   localparam logic [1:0] SIZE_BYTE      = 2'b00;
   localparam logic [1:0] SIZE_HALF      = 2'b01;
   localparam logic [1:0] SIZE_WORD      = 2'b10;

   localparam logic [BUF_SIZE_LOG-1:0] IDX_ONE = {{(BUF_SIZE_LOG-1){1'b0}}, 1'b1};

   // Lifecycle of one buffer slot
   typedef enum logic [1:0] {
      S_NOT_USED  = 2'd0,
      S_ISSUED    = 2'd1,
      S_EXECUTING = 2'd2,
      S_EXECUTED  = 2'd3
   } e_state_t;

   // One reorder-buffer slot as seen by every unit that touches the buffer
   typedef struct packed {
      e_state_t               e_state;
      logic [SPEC_TAG_W-1:0]  speculative_tag;
      logic [31:0]            pc;
      logic [2:0]             rwmm;
      logic [4:0]             Dest;
      logic [31:0]            result;
      logic [TAG_W-1:0]       tag;
      logic [31:0]            A;
      logic                   A_rdy;
      logic [31:0]            Vk;
   } entry_t;

   function automatic logic rwmm_is_write(input logic [2:0] rwmm);
      return rwmm[RWMM_WRITE_BIT];
   endfunction

   function automatic logic [1:0] rwmm_size(input logic [2:0] rwmm);
      return rwmm[1:0];
   endfunction

   // Buffer index increment; wraps naturally at BUF_SIZE
   function automatic logic [BUF_SIZE_LOG-1:0] next_idx(input logic [BUF_SIZE_LOG-1:0] idx);
      return idx + IDX_ONE;
   endfunction

endpackage

// File: rtl/retire_unit_if.sv
// Signal bundle between the retire stage and the rest of the core: buffer
// contents in, retirement/register-file/store-handshake results out.
// The master side is the retire unit and the slave side is its environment.
interface retire_unit_if;
   import retire_unit_pkg::*;

   entry_t                  entries [BUF_SIZE];
   logic [BUF_SIZE_LOG-1:0] head;
   logic                    retire_valid;
   logic [BUF_SIZE_LOG-1:0] retire_idx;
   logic [31:0]             retire_pc;
   logic                    rf_we;
   logic [4:0]              rf_waddr;
   logic [31:0]             rf_wdata;
   logic [TAG_W-1:0]        rf_wtag;
   logic                    mem_req;
   logic [31:0]             mem_addr;
   logic [31:0]             mem_wdata;
   logic [1:0]              mem_size;
   logic                    mem_ack;
   logic [63:0]             instret;

   modport master (
      input  entries, mem_ack,
      output head, retire_valid, retire_idx, retire_pc,
             rf_we, rf_waddr, rf_wdata, rf_wtag,
             mem_req, mem_addr, mem_wdata, mem_size, instret
   );

   modport slave (
      output entries, mem_ack,
      input  head, retire_valid, retire_idx, retire_pc,
             rf_we, rf_waddr, rf_wdata, rf_wtag,
             mem_req, mem_addr, mem_wdata, mem_size, instret
   );

endinterface

// File: rtl/retire_unit.sv
// In-order retirement stage. Watches the reorder-buffer slot at the head
// pointer; once that slot has executed and is no longer speculative it is
// committed. Commit means a register-file write for ordinary instructions,
// or a held store request for stores. The slot is then released and the head
// advances. All state moves on the falling clock edge, and every output is a
// register.
module retire_unit
   import retire_unit_pkg::*;
(
   input logic           clk,
   input logic           reset,
   retire_unit_if.master bus
);

   localparam logic [0:0] RT_RUN      = 1'b0;
   localparam logic [0:0] RT_MEM_WAIT = 1'b1;

   logic [0:0]              state_r;
   logic [BUF_SIZE_LOG-1:0] head_r;
   logic [63:0]             instret_r;
   logic                    retire_valid_r;
   logic [BUF_SIZE_LOG-1:0] retire_idx_r;
   logic [31:0]             retire_pc_r;
   logic                    rf_we_r;
   logic [4:0]              rf_waddr_r;
   logic [31:0]             rf_wdata_r;
   logic [TAG_W-1:0]        rf_wtag_r;
   logic                    mem_req_r;
   logic [31:0]             mem_addr_r;
   logic [31:0]             mem_wdata_r;
   logic [1:0]              mem_size_r;
   // pc of the store in flight, so later edits to the slot cannot leak into retire_pc
   logic [31:0]             store_pc_r;

   entry_t                  head_entry_s;
   logic                    ready_s;
   logic                    store_s;

   // Decode whether the head slot may commit now and whether it is a store.
   always_comb begin
      head_entry_s = bus.entries[head_r];
      store_s      = rwmm_is_write(head_entry_s.rwmm);
      ready_s      = 1'b0;
      if ((head_entry_s.e_state == S_EXECUTED) &&
          (head_entry_s.speculative_tag == {SPEC_TAG_W{1'b0}})) begin
         if (store_s) begin
            // a store also needs its address operand resolved
            ready_s = head_entry_s.A_rdy;
         end else begin
            ready_s = 1'b1;
         end
      end else begin
         ready_s = 1'b0;
      end
   end

   // Retirement FSM, head/instret bookkeeping and all registered outputs.
   always_ff @(negedge clk) begin
      if (reset) begin
         // a store still waiting for mem_ack is dropped here
         state_r        <= RT_RUN;
         head_r         <= {BUF_SIZE_LOG{1'b0}};
         instret_r      <= 64'd0;
         retire_valid_r <= 1'b0;
         retire_idx_r   <= {BUF_SIZE_LOG{1'b0}};
         retire_pc_r    <= 32'd0;
         rf_we_r        <= 1'b0;
         rf_waddr_r     <= 5'd0;
         rf_wdata_r     <= 32'd0;
         rf_wtag_r      <= {TAG_W{1'b0}};
         mem_req_r      <= 1'b0;
         mem_addr_r     <= 32'd0;
         mem_wdata_r    <= 32'd0;
         mem_size_r     <= 2'b00;
         store_pc_r     <= 32'd0;
      end else begin
         // pulses default low; data outputs keep their last value
         retire_valid_r <= 1'b0;
         rf_we_r        <= 1'b0;
         case (state_r)
            RT_RUN: begin
               if (ready_s && !store_s) begin
                  retire_valid_r <= 1'b1;
                  retire_idx_r   <= head_r;
                  retire_pc_r    <= head_entry_s.pc;
                  // r0 is hardwired, so its result is dropped
                  rf_we_r        <= (head_entry_s.Dest != 5'd0);
                  rf_waddr_r     <= head_entry_s.Dest;
                  rf_wdata_r     <= head_entry_s.result;
                  rf_wtag_r      <= head_entry_s.tag;
                  head_r         <= next_idx(head_r);
                  instret_r      <= instret_r + 64'd1;
                  state_r        <= RT_RUN;
               end else if (ready_s && store_s) begin
                  // capture the store now; the slot may change under us while waiting
                  mem_req_r      <= 1'b1;
                  mem_addr_r     <= head_entry_s.A;
                  mem_wdata_r    <= head_entry_s.Vk;
                  mem_size_r     <= rwmm_size(head_entry_s.rwmm);
                  store_pc_r     <= head_entry_s.pc;
                  state_r        <= RT_MEM_WAIT;
               end else begin
                  state_r        <= RT_RUN;
               end
            end
            RT_MEM_WAIT: begin
               if (bus.mem_ack) begin
                  mem_req_r      <= 1'b0;
                  retire_valid_r <= 1'b1;
                  retire_idx_r   <= head_r;
                  retire_pc_r    <= store_pc_r;
                  head_r         <= next_idx(head_r);
                  instret_r      <= instret_r + 64'd1;
                  state_r        <= RT_RUN;
               end else begin
                  state_r        <= RT_MEM_WAIT;
               end
            end
            default: begin
               mem_req_r <= 1'b0;
               state_r   <= RT_RUN;
            end
         endcase
      end
   end

   assign bus.head         = head_r;
   assign bus.instret      = instret_r;
   assign bus.retire_valid = retire_valid_r;
   assign bus.retire_idx   = retire_idx_r;
   assign bus.retire_pc    = retire_pc_r;
   assign bus.rf_we        = rf_we_r;
   assign bus.rf_waddr     = rf_waddr_r;
   assign bus.rf_wdata     = rf_wdata_r;
   assign bus.rf_wtag      = rf_wtag_r;
   assign bus.mem_req      = mem_req_r;
   assign bus.mem_addr     = mem_addr_r;
   assign bus.mem_wdata    = mem_wdata_r;
   assign bus.mem_size     = mem_size_r;

endmodule

// File: tb/tb_retire_unit.sv
// Directed bench for retire_unit. Expected retirements are queued when an
// entry is made ready and matched against each retire_valid pulse.
// Outputs change on the falling edge and are sampled on the rising edge;
// inputs are driven 1 time unit after the rising edge.
module tb_retire_unit;
   import retire_unit_pkg::*;

   typedef struct {
      logic [BUF_SIZE_LOG-1:0] idx;
      logic [31:0]             pc;
      logic                    store;
      logic                    we;
      logic [4:0]              waddr;
      logic [31:0]             wdata;
      logic [TAG_W-1:0]        wtag;
   } exp_t;

   logic clk;
   logic reset;
   int   checks;
   int   failures;
   exp_t exp_q [$];

   logic                    s_rv;
   logic [BUF_SIZE_LOG-1:0] s_idx;
   logic [31:0]             s_pc;
   logic                    s_rf_we;
   logic [4:0]              s_waddr;
   logic [31:0]             s_wdata;
   logic [TAG_W-1:0]        s_wtag;
   logic [BUF_SIZE_LOG-1:0] s_head;
   logic [63:0]             s_instret;
   logic                    s_req;
   logic [31:0]             s_addr;
   logic [31:0]             s_mdata;
   logic [1:0]              s_size;

   retire_unit_if bus ();

   retire_unit dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic entry_t mk_alu(input logic [31:0] pc, input logic [4:0] dest,
                                     input logic [31:0] res, input logic [TAG_W-1:0] tag);
      entry_t e;
      e         = '0;
      e.e_state = S_EXECUTED;
      e.pc      = pc;
      e.Dest    = dest;
      e.result  = res;
      e.tag     = tag;
      return e;
   endfunction

   function automatic entry_t mk_st(input logic [31:0] pc, input logic [31:0] a,
                                    input logic [31:0] vk, input logic [2:0] rwmm,
                                    input logic [TAG_W-1:0] tag);
      entry_t e;
      e         = '0;
      e.e_state = S_EXECUTED;
      e.pc      = pc;
      e.A       = a;
      e.A_rdy   = 1'b1;
      e.Vk      = vk;
      e.rwmm    = rwmm;
      e.Dest    = 5'd3;
      e.result  = 32'hBAD0_BAD0;
      e.tag     = tag;
      return e;
   endfunction

   // Queue the retirement this entry should eventually produce
   task automatic push_ret(input logic [BUF_SIZE_LOG-1:0] idx, input entry_t e);
      exp_t x;
      x.idx   = idx;
      x.pc    = e.pc;
      x.store = e.rwmm[2];
      x.we    = (!x.store) && (e.Dest != 5'd0);
      x.waddr = e.Dest;
      x.wdata = e.result;
      x.wtag  = e.tag;
      exp_q.push_back(x);
   endtask

   // One clock: sample outputs, score any retirement, free the slot, then step off the edge
   task automatic cyc();
      exp_t x;
      @(posedge clk);
      s_rv      = bus.retire_valid;
      s_idx     = bus.retire_idx;
      s_pc      = bus.retire_pc;
      s_rf_we   = bus.rf_we;
      s_waddr   = bus.rf_waddr;
      s_wdata   = bus.rf_wdata;
      s_wtag    = bus.rf_wtag;
      s_head    = bus.head;
      s_instret = bus.instret;
      s_req     = bus.mem_req;
      s_addr    = bus.mem_addr;
      s_mdata   = bus.mem_wdata;
      s_size    = bus.mem_size;
      if (s_rf_we) chk("rf_we_without_retire", 64'(s_rv), 64'd1);
      if (s_rv) begin
         chk("retire_expected", 64'(exp_q.size() > 0), 64'd1);
         if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            chk("sb_idx", 64'(s_idx), 64'(x.idx));
            chk("sb_pc", 64'(s_pc), 64'(x.pc));
            chk("sb_rf_we", 64'(s_rf_we), 64'(x.we));
            if (!x.store) begin
               chk("sb_waddr", 64'(s_waddr), 64'(x.waddr));
               chk("sb_wdata", 64'(s_wdata), 64'(x.wdata));
               chk("sb_wtag", 64'(s_wtag), 64'(x.wtag));
            end
         end
         bus.entries[s_idx].e_state = S_NOT_USED;
      end
      #1;
   endtask

   initial begin
      checks      = 0;
      failures    = 0;
      reset       = 1'b1;
      bus.mem_ack = 1'b0;
      for (int i = 0; i < BUF_SIZE; i++) bus.entries[i] = '0;

      // reset state
      cyc();
      cyc();
      chk("rst_head", 64'(s_head), 64'd0);
      chk("rst_instret", s_instret, 64'd0);
      chk("rst_rv", 64'(s_rv), 64'd0);
      chk("rst_req", 64'(s_req), 64'd0);
      chk("rst_rf_we", 64'(s_rf_we), 64'd0);
      reset = 1'b0;

      // back-to-back retirement, including Dest 0
      bus.entries[0] = mk_alu(32'h100, 5'd5, 32'h11, 5'd0);
      bus.entries[1] = mk_alu(32'h104, 5'd0, 32'h22, 5'd1);
      bus.entries[2] = mk_alu(32'h108, 5'd7, 32'h33, 5'd2);
      push_ret(4'd0, bus.entries[0]);
      push_ret(4'd1, bus.entries[1]);
      push_ret(4'd2, bus.entries[2]);
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("t1_pulse", 64'(s_rv), 64'd1);
      end
      cyc();
      chk("t1_quiet", 64'(s_rv), 64'd0);
      chk("t1_head", 64'(s_head), 64'd3);
      chk("t1_instret", s_instret, 64'd3);
      chk("t1_wdata_hold", 64'(s_wdata), 64'h33);
      chk("t1_sb_empty", 64'(exp_q.size()), 64'd0);

      // head still executing; mem_ack noise must be ignored with no store pending
      bus.entries[3] = mk_alu(32'h10C, 5'd9, 32'h44, 5'd3);
      bus.entries[3].e_state = S_EXECUTING;
      bus.mem_ack = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cyc();
         chk("t2_wait_rv", 64'(s_rv), 64'd0);
         chk("t2_wait_req", 64'(s_req), 64'd0);
      end
      bus.mem_ack = 1'b0;
      bus.entries[3].e_state = S_EXECUTED;
      push_ret(4'd3, bus.entries[3]);
      cyc();
      chk("t2_pulse", 64'(s_rv), 64'd1);
      chk("t2_head", 64'(s_head), 64'd4);
      chk("t2_instret", s_instret, 64'd4);

      // store with delayed ack; slot edits during the wait must not show
      bus.entries[4] = mk_st(32'h110, 32'h0000_1000, 32'hDEAD_BEEF, 3'b110, 5'd4);
      push_ret(4'd4, bus.entries[4]);
      for (int k = 0; k < 3; k++) begin
         cyc();
         chk("t3_req", 64'(s_req), 64'd1);
         chk("t3_addr", 64'(s_addr), 64'h1000);
         chk("t3_wdata", 64'(s_mdata), 64'hDEAD_BEEF);
         chk("t3_size", 64'(s_size), 64'(SIZE_WORD));
         chk("t3_rv", 64'(s_rv), 64'd0);
         chk("t3_head", 64'(s_head), 64'd4);
         if (k == 0) begin
            bus.entries[4].A    = 32'h0000_2000;
            bus.entries[4].Vk   = 32'h0;
            bus.entries[4].rwmm = 3'b100;
         end
      end
      bus.mem_ack = 1'b1;
      cyc();
      bus.mem_ack = 1'b0;
      chk("t3_req_drop", 64'(s_req), 64'd0);
      chk("t3_pulse", 64'(s_rv), 64'd1);
      chk("t3_head_adv", 64'(s_head), 64'd5);
      chk("t3_instret", s_instret, 64'd5);
      cyc();
      chk("t3_single", 64'(s_rv), 64'd0);

      // speculative head waits until the tag clears
      bus.entries[5] = mk_alu(32'h114, 5'd1, 32'h55, 5'd5);
      bus.entries[5].speculative_tag = 6'h01;
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("t5_spec_rv", 64'(s_rv), 64'd0);
      end
      bus.entries[5].speculative_tag = 6'h00;
      push_ret(4'd5, bus.entries[5]);
      cyc();
      chk("t5_pulse", 64'(s_rv), 64'd1);
      chk("t5_head", 64'(s_head), 64'd6);

      // fill slots 6..14 to bring head up to 15
      for (int i = 6; i < 15; i++) begin
         bus.entries[i] = mk_alu(32'h100 + 32'(i * 4), 5'(i), 32'h1000 + 32'(i), 5'(i + 16));
         push_ret(4'(i), bus.entries[i]);
      end
      for (int i = 0; i < 9; i++) begin
         cyc();
         chk("bulk_pulse", 64'(s_rv), 64'd1);
      end
      chk("bulk_head", 64'(s_head), 64'd15);

      // wrap 15 -> 0
      bus.entries[15] = mk_alu(32'h13C, 5'd31, 32'hFFFF_0000, 5'd31);
      bus.entries[0]  = mk_alu(32'h140, 5'd2, 32'h0000_FFFF, 5'd16);
      push_ret(4'd15, bus.entries[15]);
      push_ret(4'd0, bus.entries[0]);
      cyc();
      chk("wrap_idx15", 64'(s_idx), 64'd15);
      chk("wrap_head0", 64'(s_head), 64'd0);
      cyc();
      chk("wrap_idx0", 64'(s_idx), 64'd0);
      chk("wrap_head1", 64'(s_head), 64'd1);
      chk("wrap_instret", s_instret, 64'd17);
      cyc();
      chk("wrap_quiet", 64'(s_rv), 64'd0);
      chk("wrap_sb_empty", 64'(exp_q.size()), 64'd0);

      // reset while a store waits: abandon it
      bus.entries[1] = mk_st(32'h144, 32'h0000_2002, 32'h0000_BEEF, 3'b101, 5'd17);
      cyc();
      chk("t6_req", 64'(s_req), 64'd1);
      chk("t6_size", 64'(s_size), 64'(SIZE_HALF));
      chk("t6_addr", 64'(s_addr), 64'h2002);
      cyc();
      chk("t6_req_hold", 64'(s_req), 64'd1);
      reset = 1'b1;
      cyc();
      chk("t6_rst_req", 64'(s_req), 64'd0);
      chk("t6_rst_head", 64'(s_head), 64'd0);
      chk("t6_rst_instret", s_instret, 64'd0);
      chk("t6_rst_rv", 64'(s_rv), 64'd0);
      chk("t6_rst_addr", 64'(s_addr), 64'd0);
      chk("t6_rst_pc", 64'(s_pc), 64'd0);
      for (int i = 0; i < BUF_SIZE; i++) bus.entries[i] = '0;
      cyc();
      reset = 1'b0;
      cyc();
      cyc();
      chk("t6_after_req", 64'(s_req), 64'd0);
      chk("t6_after_rv", 64'(s_rv), 64'd0);
      chk("t6_after_head", 64'(s_head), 64'd0);
      chk("final_sb_empty", 64'(exp_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
